// File: rtl/motor_mixer.sv
// X-quad motor mixer: one shared signed adder walks the four motors, then a clamp stage.
// Build with MOTOR_MIXER_SLEW_LIMIT_EN to rate-limit each output per update.
module motor_mixer #(
    parameter int                   RATE_BIT_WIDTH  = 16,
    parameter int                   MOTOR_BIT_WIDTH = 16,
    parameter int                   RATE_SHIFT      = 4,
    parameter logic [MOTOR_BIT_WIDTH-1:0] MOTOR_MIN     = 16'd0,
    parameter logic [MOTOR_BIT_WIDTH-1:0] MOTOR_MAX     = 16'd1000,
    parameter logic [MOTOR_BIT_WIDTH-1:0] THROTTLE_IDLE = 16'd20,
    parameter logic [MOTOR_BIT_WIDTH-1:0] SLEW_STEP     = 16'd50
) (
    input  logic                       us_clk,
    input  logic                       resetn,
    input  logic [RATE_BIT_WIDTH-1:0]  yaw_rate,
    input  logic [RATE_BIT_WIDTH-1:0]  roll_rate,
    input  logic [RATE_BIT_WIDTH-1:0]  pitch_rate,
    input  logic [MOTOR_BIT_WIDTH-1:0] throttle,
    input  logic                       start_signal,
    output logic [MOTOR_BIT_WIDTH-1:0] motor_1_rate,
    output logic [MOTOR_BIT_WIDTH-1:0] motor_2_rate,
    output logic [MOTOR_BIT_WIDTH-1:0] motor_3_rate,
    output logic [MOTOR_BIT_WIDTH-1:0] motor_4_rate,
    output logic                       complete_signal,
    output logic                       busy
);
    localparam int MBW    = MOTOR_BIT_WIDTH;
    localparam int WORK_W = ((MOTOR_BIT_WIDTH > RATE_BIT_WIDTH) ? MOTOR_BIT_WIDTH : RATE_BIT_WIDTH) + 4;

    localparam logic signed [WORK_W-1:0] MIN_S  = $signed({{(WORK_W-MBW){1'b0}}, MOTOR_MIN});
    localparam logic signed [WORK_W-1:0] MAX_S  = $signed({{(WORK_W-MBW){1'b0}}, MOTOR_MAX});
    localparam logic signed [WORK_W-1:0] IDLE_S = $signed({{(WORK_W-MBW){1'b0}}, THROTTLE_IDLE});

    typedef enum logic [2:0] {
        WAITING  = 3'd0,
        MIX1     = 3'd1,
        MIX2     = 3'd2,
        MIX3     = 3'd3,
        MIX4     = 3'd4,
        CLAMP    = 3'd5,
        COMPLETE = 3'd6
    } state_t;

    state_t                    state_q, state_d;
    logic                      start_prev_q;
    logic                      busy_q, busy_d;
    logic                      complete_q, complete_d;
    logic signed [WORK_W-1:0]  t_q, t_d, p_q, p_d, r_q, r_d, y_q, y_d;
    logic signed [WORK_W-1:0]  w_q [4];
    logic signed [WORK_W-1:0]  w_d [4];
    logic [MBW-1:0]            motor_q [4];
    logic [MBW-1:0]            motor_d [4];
    logic [MBW-1:0]            mix_val [4];

    logic                      neg_p, neg_r, neg_y;
    logic [1:0]                mix_idx;
    logic signed [WORK_W-1:0]  p_term, r_term, y_term, mix_sum;
    logic                      trigger, idle;

    function automatic logic signed [WORK_W-1:0] ext_rate(input logic signed [RATE_BIT_WIDTH-1:0] r);
        return WORK_W'(r >>> RATE_SHIFT);
    endfunction

    assign trigger = start_signal && !start_prev_q;
    assign idle    = (t_q <= IDLE_S);

    // Sign pattern of the X mix for whichever motor the shared adder serves this cycle.
    always_comb begin
        neg_p   = 1'b0;
        neg_r   = 1'b0;
        neg_y   = 1'b0;
        mix_idx = 2'd0;
        case (state_q)
            MIX1: begin mix_idx = 2'd0; neg_y = 1'b1; end
            MIX2: begin mix_idx = 2'd1; neg_r = 1'b1; end
            MIX3: begin mix_idx = 2'd2; neg_p = 1'b1; neg_r = 1'b1; neg_y = 1'b1; end
            MIX4: begin mix_idx = 2'd3; neg_p = 1'b1; end
            default: ;
        endcase
    end

    assign p_term  = neg_p ? -p_q : p_q;
    assign r_term  = neg_r ? -r_q : r_q;
    assign y_term  = neg_y ? -y_q : y_q;
    assign mix_sum = t_q + p_term + r_term + y_term;

    for (genvar gi = 0; gi < 4; gi++) begin : g_motor
        logic [MBW-1:0] clamp_val;
        logic [MBW-1:0] out_val;

        always_comb begin
            if (w_q[gi] < MIN_S)
                clamp_val = MOTOR_MIN;
            else if (w_q[gi] > MAX_S)
                clamp_val = MOTOR_MAX;
            else
                clamp_val = MBW'(w_q[gi]);
        end

`ifdef MOTOR_MIXER_SLEW_LIMIT_EN
        logic signed [MBW+1:0] prev_s, tgt_s, up_s, dn_s;

        // Idle cut-off bypasses the limiter so motors stop immediately.
        always_comb begin
            prev_s = $signed({2'b00, motor_q[gi]});
            tgt_s  = $signed({2'b00, clamp_val});
            up_s   = prev_s + $signed({2'b00, SLEW_STEP});
            dn_s   = prev_s - $signed({2'b00, SLEW_STEP});
            if (idle)
                out_val = MOTOR_MIN;
            else if (tgt_s > up_s)
                out_val = MBW'(up_s);
            else if (tgt_s < dn_s)
                out_val = MBW'(dn_s);
            else
                out_val = clamp_val;
        end
`else
        assign out_val = idle ? MOTOR_MIN : clamp_val;
`endif

        assign mix_val[gi] = out_val;
    end

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        complete_d = 1'b0;
        t_d        = t_q;
        p_d        = p_q;
        r_d        = r_q;
        y_d        = y_q;
        w_d        = w_q;
        motor_d    = motor_q;
        case (state_q)
            WAITING: begin
                if (trigger) begin
                    t_d     = $signed({{(WORK_W-MBW){1'b0}}, throttle});
                    p_d     = ext_rate(pitch_rate);
                    r_d     = ext_rate(roll_rate);
                    y_d     = ext_rate(yaw_rate);
                    busy_d  = 1'b1;
                    state_d = MIX1;
                end
            end
            MIX1: begin w_d[mix_idx] = mix_sum; state_d = MIX2;  end
            MIX2: begin w_d[mix_idx] = mix_sum; state_d = MIX3;  end
            MIX3: begin w_d[mix_idx] = mix_sum; state_d = MIX4;  end
            MIX4: begin w_d[mix_idx] = mix_sum; state_d = CLAMP; end
            CLAMP: begin
                motor_d    = mix_val;
                complete_d = 1'b1;
                state_d    = COMPLETE;
            end
            COMPLETE: begin
                busy_d  = 1'b0;
                state_d = WAITING;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = WAITING;
            end
        endcase
    end

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= WAITING;
            start_prev_q <= 1'b0;
            busy_q       <= 1'b0;
            complete_q   <= 1'b0;
            t_q          <= '0;
            p_q          <= '0;
            r_q          <= '0;
            y_q          <= '0;
            for (int i = 0; i < 4; i++) begin
                w_q[i]     <= '0;
                motor_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_signal;
            busy_q       <= busy_d;
            complete_q   <= complete_d;
            t_q          <= t_d;
            p_q          <= p_d;
            r_q          <= r_d;
            y_q          <= y_d;
            w_q          <= w_d;
            motor_q      <= motor_d;
        end
    end

    assign motor_1_rate    = motor_q[0];
    assign motor_2_rate    = motor_q[1];
    assign motor_3_rate    = motor_q[2];
    assign motor_4_rate    = motor_q[3];
    assign complete_signal = complete_q;
    assign busy            = busy_q;

endmodule
